muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for RV32M multiply/divide operations in the Execute stage. It accepts an M-extension operation from the ID/EX register and runs a 32-iteration shift-add multiply or restoring divide. While the operation runs, it stalls the front of the pipeline. It presents the result for one cycle so that EX_to_MEM captures it in place of the ALU output.

---
 rtl/muldiv_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit for the Execute stage.
// Runs a 32-iteration shift-add multiply or a restoring divide. It stalls the
// front of the pipeline while it works and presents the result for one cycle.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           M-op present in EX
//   funct3          M-op select (MUL..REMU)
//   op_a, op_b      rs1 / rs2 operand values
//   flush           squash the in-flight operation
//   stall           combinational freeze of IF, ID/EX and EX_to_MEM
//   busy            registered, high while iterating
//   done            registered, one-cycle result-valid pulse
//   result          registered, last completed result
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3;
  logic             neg;
  // hi/lo double as product accumulator (mul) or remainder/quotient (div)
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  mcand;

  // Acceptance-time decode: operand signedness, magnitudes, result sign, special divides
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            neg_in;
  logic            is_div;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed    = (funct3 == F_MUL) || (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                  (funct3 == F_DIV) || (funct3 == F_REM);
    b_signed    = (funct3 == F_MUL) || (funct3 == F_MULH) ||
                  (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg       = a_signed && op_a[XLEN-1];
    b_neg       = b_signed && op_b[XLEN-1];
    mag_a       = a_neg ? (XLEN'(0) - op_a) : op_a;
    mag_b       = b_neg ? (XLEN'(0) - op_b) : op_b;
    // remainder takes the dividend's sign only
    neg_in      = a_neg ^ (b_neg && (funct3 != F_REM));
    is_div      = funct3[2];
    div_zero    = is_div && (op_b == '0);
    div_ovf     = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                  (op_a == MIN_INT) && (op_b == ALL_ONE);
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? op_a : ALL_ONE;
    else if (div_ovf) special_res = funct3[1] ? '0 : MIN_INT;
  end

  // One iteration of multiply and of restoring divide, plus final result select
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic              div_ok;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_trial = div_shift - {1'b0, mcand};
    div_ok    = (div_shift >= {1'b0, mcand});
    if (f3[2]) begin
      hi_n = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], div_ok};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod_s = neg ? ((2*XLEN)'(0) - {hi_n, lo_n}) : {hi_n, lo_n};
    case (f3)
      F_MUL:                      final_res = prod_s[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              final_res = neg ? (XLEN'(0) - lo_n) : lo_n;
      default:                    final_res = neg ? (XLEN'(0) - hi_n) : hi_n;
    endcase
  end

  // Freeze the pipeline in the same cycle the M-op is accepted
  assign stall = ((state == IDLE) && start && !flush) || (state == RUN);

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      f3     <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            f3  <= funct3;
            neg <= neg_in;
            cnt <= '0;
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              hi    <= '0;
              lo    <= is_div ? mag_a : mag_b;
              mcand <= is_div ? mag_b : mag_a;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            result <= final_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed, table-driven bench for muldiv_sequencer.
// Each table entry is started in a fresh cycle 0 and tracked cycle by cycle
// for stall/busy/done counts, done position and result; hand-written
// sequences cover flush, reset and start-with-flush corner cases.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle (cycle 0) and follow it to cycle lat+1
  task automatic run_op(input vec_t v);
    int stall_cnt;
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    logic [31:0] res_at_done;
    stall_cnt   = 0;
    busy_cnt    = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    res_at_done = 32'hDEADBEEF;
    start  = 1'b1;
    funct3 = v.f3;
    op_a   = v.a;
    op_b   = v.b;
    #1;
    if (stall) stall_cnt++;
    if (busy)  busy_cnt++;
    if (done)  done_cnt++;
    for (int c = 1; c <= v.lat + 1; c++) begin
      next_cycle();
      start  = 1'b0;
      funct3 = ~v.f3;
      op_a   = ~v.a;
      op_b   = v.b ^ 32'h5A5A_0001;
      #1;
      if (stall) stall_cnt++;
      if (busy)  busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc    = c;
          res_at_done = result;
        end
      end
    end
    chk({v.name, " result"},     res_at_done,      v.exp);
    chk({v.name, " done_cycle"}, 32'(done_cyc),    32'(v.lat));
    chk({v.name, " done_count"}, 32'(done_cnt),    32'd1);
    chk({v.name, " stall_cyc"},  32'(stall_cnt),   32'(v.lat));
    chk({v.name, " busy_cyc"},   32'(busy_cnt),    32'(v.lat - 1));
    // leave the bench in cycle lat+1, IDLE, ready for a back-to-back issue
    next_cycle();
  endtask

  initial begin
    vec_t v;
    logic [31:0] prev;
    int done_seen;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3"};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU ff*ff"};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "MULH -1*-1"};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "MULHSU -1*2"};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "DIV -7/2"};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "REM -7%2"};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33, "DIVU 100/7"};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33, "REMU 100%7"};
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "DIVU 5/0"};
    vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1,  "REMU 5%0"};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV ovf"};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "REM ovf"};
    vecs[12] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min*min"};
    vecs[13] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2"};
    vecs[14] = '{3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, "REM -7%-2"};

    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset stall",  32'(stall), 32'd0);
    chk("reset busy",   32'(busy),  32'd0);
    chk("reset done",   32'(done),  32'd0);
    chk("reset result", result,     32'd0);
    next_cycle();

    // back-to-back table run: each op starts in the IDLE cycle after the previous
    for (int i = 0; i < NVEC; i++) run_op(vecs[i]);

    // flush at cycle 10 of MUL 3*4
    prev   = vecs[NVEC-1].exp;
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd4;
    done_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      start = 1'b0;
      if (done) done_seen++;
    end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    #1;
    chk("flush10 stall",  32'(stall), 32'd0);
    chk("flush10 busy",   32'(busy),  32'd0);
    chk("flush10 done",   32'(done + 1'b0) + 32'(done_seen), 32'd0);
    chk("flush10 result", result,     prev);
    next_cycle();
    v = '{3'b000, 32'd3, 32'd4, 32'd12, 33, "MUL 3*4 after flush"};
    run_op(v);

    // flush in the last RUN cycle: done must never pulse
    prev   = 32'd12;
    start  = 1'b1;
    funct3 = 3'b011;
    op_a   = 32'hFFFF_FFFF;
    op_b   = 32'hFFFF_FFFF;
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      start = 1'b0;
    end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (done) done_seen++;
      next_cycle();
    end
    chk("flush31 done pulses", 32'(done_seen), 32'd0);
    chk("flush31 busy",        32'(busy),      32'd0);
    chk("flush31 result",      result,         prev);

    // reset at cycle 20 of DIVU 100/7
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      start = 1'b0;
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rst20 busy",   32'(busy),  32'd0);
    chk("rst20 done",   32'(done),  32'd0);
    chk("rst20 stall",  32'(stall), 32'd0);
    chk("rst20 result", result,     32'd0);
    next_cycle();

    // start together with flush in IDLE is not accepted
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd9;
    op_b   = 32'd9;
    #1;
    chk("startflush stall", 32'(stall), 32'd0);
    next_cycle();
    start = 1'b0;
    flush = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (done || busy || stall) done_seen++;
      next_cycle();
    end
    chk("startflush idle", 32'(done_seen), 32'd0);
    chk("startflush result", result, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
